key_debounce: RTL and testbench

Four-channel push-button front end: the input-side counterpart of the board's LED drivers. Each of four active-low, asynchronous key pins is synchronized, debounced by a stable-time counter, and converted into a clean level plus single-cycle press, release and long-press event pulses. Downstream pattern and mode logic consumes only these registered events and never touches the raw pins.

---
 rtl/key_debounce.sv | 160 ++++++++++++++++
 tb/tb_key_debounce.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: four-channel push-button front end.
//
// Each active-low, asynchronous key pin goes through a two-flop synchronizer and
// a stable-time debounce counter. The result is a clean pressed level plus
// single-cycle press, release and long-press pulses. Every output is a flop.
//
// Ports:
//   sys_clk      system clock, all logic on its rising edge
//   sys_rst      synchronous active-high reset
//   key0..key3   raw key pins, active-low (0 = pressed), asynchronous
//   key_level    debounced state, bit i = 1 while key i is pressed
//   key_press    one-cycle pulse on a 0->1 edge of key_level[i]
//   key_release  one-cycle pulse on a 1->0 edge of key_level[i]
//   key_long     one-cycle pulse once per press after LONG+1 cycles held
//   key_valid    one-cycle pulse when any key_press bit is set
//   key_num      lowest set index of key_press, held between pulses
module key_debounce #(
   parameter logic [19:0] DEBOUNCE = 20'd999_999,
   parameter logic [24:0] LONG     = 25'd24_999_999
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key0,
   input  logic       key1,
   input  logic       key2,
   input  logic       key3,
   output logic [3:0] key_level,
   output logic [3:0] key_press,
   output logic [3:0] key_release,
   output logic [3:0] key_long,
   output logic       key_valid,
   output logic [1:0] key_num
);

   localparam int unsigned NumKeys = 4;

   logic [3:0]  key_raw;
   logic [3:0]  meta_q;
   logic [3:0]  sync_q;
   logic [3:0]  sync_pressed;

   logic [19:0] cnt_q  [NumKeys];
   logic [19:0] cnt_d  [NumKeys];
   logic [24:0] hold_q [NumKeys];
   logic [24:0] hold_d [NumKeys];
   logic [3:0]  done_q, done_d;

   logic [3:0]  level_q, level_d;
   logic [3:0]  press_q, press_d;
   logic [3:0]  release_q, release_d;
   logic [3:0]  long_q, long_d;
   logic        valid_q, valid_d;
   logic [1:0]  num_q, num_d;

   assign key_raw      = {key3, key2, key1, key0};
   // Second synchronizer stage inverted so 1 means pressed.
   assign sync_pressed = ~sync_q;

   // Synchronizer: reset to released so a key held through reset is seen as
   // a fresh press once reset lifts.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= key_raw;
         sync_q <= meta_q;
      end
   end

   // Debounce and long-press next state, all channels independent.
   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      done_d    = done_q;
      for (int i = 0; i < NumKeys; i++) begin
         cnt_d[i]  = cnt_q[i];
         hold_d[i] = hold_q[i];

         // Any sample matching the current level restarts the stable count.
         if (sync_pressed[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEBOUNCE) begin
            cnt_d[i]     = '0;
            level_d[i]   = sync_pressed[i];
            press_d[i]   = sync_pressed[i];
            release_d[i] = ~sync_pressed[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 20'd1;
         end

         // Hold timer runs off the registered level; done blocks repeats
         // until the key is released.
         if (!level_q[i]) begin
            hold_d[i] = '0;
            done_d[i] = 1'b0;
         end else if (!done_q[i]) begin
            if (hold_q[i] == LONG) begin
               long_d[i] = 1'b1;
               done_d[i] = 1'b1;
            end else begin
               hold_d[i] = hold_q[i] + 25'd1;
            end
         end
      end
   end

   // Valid/index derived from the same press vector that is being registered.
   always_comb begin
      valid_d = |press_d;
      num_d   = num_q;
      if (press_d[0]) begin
         num_d = 2'd0;
      end else if (press_d[1]) begin
         num_d = 2'd1;
      end else if (press_d[2]) begin
         num_d = 2'd2;
      end else if (press_d[3]) begin
         num_d = 2'd3;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < NumKeys; i++) begin
            cnt_q[i]  <= '0;
            hold_q[i] <= '0;
         end
         done_q    <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         valid_q   <= 1'b0;
         num_q     <= 2'd0;
      end else begin
         for (int i = 0; i < NumKeys; i++) begin
            cnt_q[i]  <= cnt_d[i];
            hold_q[i] <= hold_d[i];
         end
         done_q    <= done_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         valid_q   <= valid_d;
         num_q     <= num_d;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_long    = long_q;
   assign key_valid   = valid_q;
   assign key_num     = num_q;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce: directed scenarios with literal expectations plus
// randomized pin activity, all compared every cycle against a window-based model.
module tb_key_debounce;

   localparam int D = 4;
   localparam int L = 9;
   localparam int HistLen = 8192;

   logic       sys_clk;
   logic       sys_rst;
   logic [3:0] keys;
   logic [3:0] key_level, key_press, key_release, key_long;
   logic       key_valid;
   logic [1:0] key_num;

   int n_total = 0;
   int n_pass  = 0;

   key_debounce #(
      .DEBOUNCE(20'd4),
      .LONG    (25'd9)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key0       (keys[0]),
      .key1       (keys[1]),
      .key2       (keys[2]),
      .key3       (keys[3]),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_long   (key_long),
      .key_valid  (key_valid),
      .key_num    (key_num)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ---------------- reference model ----------------
   // Pin/reset history per edge. The counter logic at edge t sees the pin
   // sampled at edge t-2, or "released" if either of the two edges before t
   // was a reset edge. A level flips at edge t when the last D+1 seen samples,
   // all taken after the previous flip/reset, disagree with the level.
   bit [3:0]   pin_hist [HistLen];
   bit         rst_hist [HistLen];
   int         cyc = 0;
   int         last_chg [4];
   int         press_at [4];
   logic [3:0] m_level, m_press, m_release, m_long;
   logic       m_valid;
   logic [1:0] m_num;

   function automatic bit seen_pressed(int t, int i);
      if (t < 2) return 1'b0;
      if (rst_hist[t-1] || rst_hist[t-2]) return 1'b0;
      return ~pin_hist[t-2][i];
   endfunction

   always @(posedge sys_clk) begin : model
      logic [3:0] np, nr, nl;
      bit         flip;
      np = '0;
      nr = '0;
      nl = '0;
      if (sys_rst) begin
         m_level = '0;
         m_num   = 2'd0;
         for (int i = 0; i < 4; i++) begin
            last_chg[i] = cyc;
            press_at[i] = -100000;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            // Long press: exactly L+1 edges after the press, level unchanged since.
            nl[i] = m_level[i] && (press_at[i] == cyc - L - 1) && (last_chg[i] == press_at[i]);
            flip = (cyc - D > last_chg[i]);
            for (int j = 0; j <= D; j++) begin
               if (seen_pressed(cyc - j, i) == m_level[i]) flip = 1'b0;
            end
            if (flip) begin
               m_level[i]  = ~m_level[i];
               last_chg[i] = cyc;
               if (m_level[i]) begin
                  np[i]       = 1'b1;
                  press_at[i] = cyc;
               end else begin
                  nr[i] = 1'b1;
               end
            end
         end
         for (int i = 3; i >= 0; i--) begin
            if (np[i]) m_num = 2'(i);
         end
      end
      m_press   = np;
      m_release = nr;
      m_long    = nl;
      m_valid   = |np;
      pin_hist[cyc] = keys;
      rst_hist[cyc] = sys_rst;
      cyc++;
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   // Literal expectation checked against both the DUT and the model.
   task automatic lit(input string name, input logic [3:0] act, input logic [3:0] mdl,
                      input logic [3:0] want);
      chk({name, "_dut"}, act, want);
      chk({name, "_model"}, mdl, want);
   endtask

   always @(negedge sys_clk) begin
      if (cyc >= 1) begin
         chk("level",   key_level,         m_level);
         chk("press",   key_press,         m_press);
         chk("release", key_release,       m_release);
         chk("long",    key_long,          m_long);
         chk("valid",   {3'b0, key_valid}, {3'b0, m_valid});
         chk("num",     {2'b0, key_num},   {2'b0, m_num});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   // ---------------- stimulus ----------------
   int rate;
   int rst_left;

   initial begin
      sys_rst = 1'b1;
      keys    = 4'hF;
      step(3);
      lit("rst_level", key_level, m_level, 4'b0000);
      lit("rst_press", key_press, m_press, 4'b0000);
      lit("rst_release", key_release, m_release, 4'b0000);
      lit("rst_long", key_long, m_long, 4'b0000);
      lit("rst_valid", {3'b0, key_valid}, {3'b0, m_valid}, 4'b0000);
      lit("rst_num", {2'b0, key_num}, {2'b0, m_num}, 4'b0000);
      sys_rst = 1'b0;
      step(50);
      lit("idle_level", key_level, m_level, 4'b0000);

      // key1 press and long press; first low sample at the next edge k.
      keys[1] = 1'b0;
      step(6);
      lit("k1_press_early", key_press, m_press, 4'b0000);
      step(1);
      lit("k1_press", key_press, m_press, 4'b0010);
      lit("k1_valid", {3'b0, key_valid}, {3'b0, m_valid}, 4'b0001);
      lit("k1_num", {2'b0, key_num}, {2'b0, m_num}, 4'b0001);
      step(1);
      lit("k1_press_gone", key_press, m_press, 4'b0000);
      lit("k1_level", key_level, m_level, 4'b0010);
      step(8);
      lit("k1_long_early", key_long, m_long, 4'b0000);
      step(1);
      lit("k1_long", key_long, m_long, 4'b0010);
      step(1);
      lit("k1_long_gone", key_long, m_long, 4'b0000);
      step(20);
      keys[1] = 1'b1;
      step(7);
      lit("k1_release", key_release, m_release, 4'b0010);
      step(10);

      // key2 bouncing, then steady low from edge m.
      keys[2] = 1'b0; step(3);
      keys[2] = 1'b1; step(2);
      keys[2] = 1'b0; step(3);
      keys[2] = 1'b1; step(1);
      keys[2] = 1'b0;
      step(6);
      lit("k2_press_early", key_press, m_press, 4'b0000);
      step(1);
      lit("k2_press", key_press, m_press, 4'b0100);
      lit("k2_num", {2'b0, key_num}, {2'b0, m_num}, 4'b0010);
      keys[2] = 1'b1;
      step(20);

      // key0 and key3 together.
      keys[0] = 1'b0;
      keys[3] = 1'b0;
      step(7);
      lit("k03_press", key_press, m_press, 4'b1001);
      lit("k03_num", {2'b0, key_num}, {2'b0, m_num}, 4'b0000);
      lit("k03_valid", {3'b0, key_valid}, {3'b0, m_valid}, 4'b0001);
      step(20);
      keys[0] = 1'b1;
      keys[3] = 1'b1;
      step(7);
      lit("k03_release", key_release, m_release, 4'b1001);
      step(10);

      // Short press on key1: release completes before the long count ends.
      keys[1] = 1'b0;
      step(7);
      lit("k1s_press", key_press, m_press, 4'b0010);
      keys[1] = 1'b1;
      step(7);
      lit("k1s_release", key_release, m_release, 4'b0010);
      step(3);
      lit("k1s_no_long", key_long, m_long, 4'b0000);
      step(10);
      keys[1] = 1'b0;
      step(7);
      lit("k1r_press", key_press, m_press, 4'b0010);
      step(10);
      lit("k1r_long", key_long, m_long, 4'b0010);
      step(5);

      // Reset in the middle of a held key1.
      sys_rst = 1'b1;
      step(1);
      lit("mid_rst_level", key_level, m_level, 4'b0000);
      lit("mid_rst_release", key_release, m_release, 4'b0000);
      step(1);
      sys_rst = 1'b0;
      step(6);
      lit("post_rst_early", key_press, m_press, 4'b0000);
      step(1);
      lit("post_rst_press", key_press, m_press, 4'b0010);
      keys[1] = 1'b1;
      step(20);

      // Randomized activity with varying bounce rates and occasional resets.
      rate     = 10;
      rst_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) rate = int'($urandom_range(30, 2));
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(rate - 1, 0) == 0) keys[i] = ~keys[i];
         end
         if (rst_left > 0) begin
            sys_rst = 1'b1;
            rst_left--;
         end else if ($urandom_range(399, 0) == 0) begin
            sys_rst  = 1'b1;
            rst_left = int'($urandom_range(2, 0));
         end else begin
            sys_rst = 1'b0;
         end
         step(1);
      end
      sys_rst = 1'b0;
      keys    = 4'hF;
      step(30);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
